// File: rtl/jtag_pkg.sv
// jtag_pkg: command byte constants and defaults shared by the USB-to-JTAG
// bitbang bridge blocks.
//   CMD_READ      'R'  sample TDO and return it over USB TX
//   CMD_LED_ON    'B'  status LED on
//   CMD_LED_OFF   'b'  status LED off
//   CMD_PIN_BASE  '0'  base of the pin-drive commands ('0'..'7')
//   CMD_RST_BASE  'r'  base of the reset-line commands
package jtag_pkg;

    localparam logic [7:0] CMD_READ     = 8'h52;
    localparam logic [7:0] CMD_LED_ON   = 8'h42;
    localparam logic [7:0] CMD_LED_OFF  = 8'h62;
    localparam logic [7:0] CMD_PIN_BASE = 8'h30;
    localparam logic [7:0] CMD_RST_BASE = 8'h72;

    localparam int DEFAULT_DEPTH = 16;

endpackage

// File: rtl/jtag_cmd_fifo.sv
// jtag_cmd_fifo: synchronous byte FIFO with flush, used by jtag_cmd_pacer.
// Ports:
//   clk_i, rst_n_i        clock, asynchronous active-low reset
//   push_i, push_data_i   write request and byte (ignored when full or flushing)
//   pop_i                 remove the head byte (ignored when empty or flushing)
//   flush_i               empty the FIFO at the next edge; a same-cycle push is lost
//   head_o                byte at the head, valid whenever empty_o is low
//   full_o, empty_o       occupancy flags
//   level_o               occupancy, 0..DEPTH
module jtag_cmd_fifo
    import jtag_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     push_i,
    input  logic [7:0]               push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    output logic [7:0]               head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_reg;
    logic [AW:0] rd_ptr_reg;
    logic        push_en;
    logic        pop_en;

    assign push_en = push_i && !full_o && !flush_i;
    assign pop_en  = pop_i && !empty_o && !flush_i;

    // The extra MSB on each pointer separates "full" from "empty" when the
    // address bits coincide.
    assign empty_o = (wr_ptr_reg == rd_ptr_reg);
    assign full_o  = (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]) &&
                     (wr_ptr_reg[AW] != rd_ptr_reg[AW]);
    assign level_o = wr_ptr_reg - rd_ptr_reg;

    // Head is read combinationally: the issue decision must see a byte the
    // cycle after it was written, leaving no room for a registered read.
    assign head_o = mem[rd_ptr_reg[AW-1:0]];

    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem[wr_ptr_reg[AW-1:0]] <= push_data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else if (flush_i) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_reg <= wr_ptr_reg + (AW+1)'(1);
            end
            if (pop_en) begin
                rd_ptr_reg <= rd_ptr_reg + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/jtag_cmd_pacer.sv
// jtag_cmd_pacer: buffers USB RX command bytes and re-issues them to the
// JTAG bitbang bridge as single-cycle strobes spaced at least div_i+1 clocks
// apart. Read-TDO commands ('R') wait at the head until USB TX has room.
// Ports:
//   clk_i, rst_n_i      clock, asynchronous active-low reset
//   usb_data_i/valid_i  incoming command byte; accepted when usb_ready_o
//   usb_ready_o         FIFO not full
//   div_i               strobe spacing minus 1, sampled at each issue
//   flush_i             discard buffered bytes and zero the spacing counter
//   tx_ready_i          USB TX can take a byte; gates 'R'
//   cmd_data_o          byte presented to the bridge (holds between strobes)
//   cmd_valid_o         one-cycle strobe, bridge consumes cmd_data_o
//   level_o             FIFO occupancy
// Build option JTAG_CMD_PACER_STATS_EN adds:
//   issued_cnt_o        wrapping count of cmd_valid_o strobes
//   stall_cnt_o         wrapping count of non-empty cycles without an issue
module jtag_cmd_pacer
    import jtag_pkg::*;
#(
    parameter int DEPTH = DEFAULT_DEPTH,
    parameter int DIV_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic [7:0]               usb_data_i,
    input  logic                     usb_valid_i,
    output logic                     usb_ready_o,
    input  logic [DIV_W-1:0]         div_i,
    input  logic                     flush_i,
    input  logic                     tx_ready_i,
    output logic [7:0]               cmd_data_o,
    output logic                     cmd_valid_o,
    output logic [$clog2(DEPTH):0]   level_o
`ifdef JTAG_CMD_PACER_STATS_EN
    ,
    output logic [15:0]              issued_cnt_o,
    output logic [15:0]              stall_cnt_o
`endif
);

    logic [7:0]       fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             issue;
    logic [DIV_W-1:0] space_cnt_reg;
    logic [DIV_W-1:0] space_cnt_next;
    logic             cmd_valid_reg;
    logic [7:0]       cmd_data_reg;

    assign usb_ready_o = !fifo_full;

    jtag_cmd_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .push_i      (usb_valid_i),
        .push_data_i (usb_data_i),
        .pop_i       (issue),
        .flush_i     (flush_i),
        .head_o      (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .level_o     (level_o)
    );

    // A blocked 'R' stalls everything behind it so command order is kept.
    assign issue = !fifo_empty && (space_cnt_reg == '0) && !flush_i &&
                   ((fifo_head != CMD_READ) || tx_ready_i);

    always_comb begin
        space_cnt_next = space_cnt_reg;
        if (flush_i) begin
            space_cnt_next = '0;
        end else if (issue) begin
            space_cnt_next = div_i;
        end else if (space_cnt_reg != '0) begin
            space_cnt_next = space_cnt_reg - DIV_W'(1);
        end
    end

    // Flush only blocks new issues; a strobe registered the cycle before
    // still goes out.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            space_cnt_reg <= '0;
            cmd_valid_reg <= 1'b0;
            cmd_data_reg  <= 8'h00;
        end else begin
            space_cnt_reg <= space_cnt_next;
            cmd_valid_reg <= issue;
            if (issue) begin
                cmd_data_reg <= fifo_head;
            end
        end
    end

    assign cmd_valid_o = cmd_valid_reg;
    assign cmd_data_o  = cmd_data_reg;

`ifdef JTAG_CMD_PACER_STATS_EN
    logic [15:0] issued_cnt_reg;
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            issued_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
        end else if (flush_i) begin
            issued_cnt_reg <= '0;
            stall_cnt_reg  <= '0;
        end else begin
            if (cmd_valid_reg) begin
                issued_cnt_reg <= issued_cnt_reg + 16'd1;
            end
            if (!fifo_empty && !issue) begin
                stall_cnt_reg <= stall_cnt_reg + 16'd1;
            end
        end
    end

    assign issued_cnt_o = issued_cnt_reg;
    assign stall_cnt_o  = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_jtag_cmd_pacer.sv
// tb_jtag_cmd_pacer: directed and randomized checks of jtag_cmd_pacer against
// a queue-based reference model that tracks the earliest cycle at which the
// next strobe may be issued. Stats checks compile in with
// JTAG_CMD_PACER_STATS_EN.
module tb_jtag_cmd_pacer;

    localparam int DEPTH = 16;
    localparam int DIV_W = 8;

    logic             clk_i       = 1'b0;
    logic             rst_n_i     = 1'b0;
    logic [7:0]       usb_data_i  = 8'h00;
    logic             usb_valid_i = 1'b0;
    logic [DIV_W-1:0] div_i       = '0;
    logic             flush_i     = 1'b0;
    logic             tx_ready_i  = 1'b1;
    logic             usb_ready_o;
    logic [7:0]       cmd_data_o;
    logic             cmd_valid_o;
    logic [4:0]       level_o;
`ifdef JTAG_CMD_PACER_STATS_EN
    logic [15:0]      issued_cnt_o;
    logic [15:0]      stall_cnt_o;
`endif

    jtag_cmd_pacer #(
        .DEPTH (DEPTH),
        .DIV_W (DIV_W)
    ) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .usb_data_i  (usb_data_i),
        .usb_valid_i (usb_valid_i),
        .usb_ready_o (usb_ready_o),
        .div_i       (div_i),
        .flush_i     (flush_i),
        .tx_ready_i  (tx_ready_i),
        .cmd_data_o  (cmd_data_o),
        .cmd_valid_o (cmd_valid_o),
        .level_o     (level_o)
`ifdef JTAG_CMD_PACER_STATS_EN
        ,
        .issued_cnt_o (issued_cnt_o),
        .stall_cnt_o  (stall_cnt_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0]  mq[$];
    longint      cyc      = 0;
    longint      next_ok  = 0;   // earliest cycle a new strobe may be issued
    logic        exp_valid = 1'b0;
    logic [7:0]  exp_data  = 8'h00;
    logic [4:0]  exp_level = 5'd0;
    logic        exp_ready = 1'b1;
    logic [15:0] exp_issued = 16'd0;
    logic [15:0] exp_stall  = 16'd0;

    task automatic model_reset();
        mq.delete();
        next_ok    = cyc;
        exp_valid  = 1'b0;
        exp_data   = 8'h00;
        exp_level  = 5'd0;
        exp_ready  = 1'b1;
        exp_issued = 16'd0;
        exp_stall  = 16'd0;
    endtask

    // Advance one clock; inputs for the current cycle must already be set.
    // Returns #1 after the edge with the model holding the new expected outputs.
    task automatic tick();
        bit         nonempty;
        bit         push_ok;
        bit         issue;
        bit         cur_strobe;
        logic [7:0] head;
        nonempty   = (mq.size() != 0);
        push_ok    = usb_valid_i && (mq.size() < DEPTH);
        head       = nonempty ? mq[0] : 8'h00;
        issue      = nonempty && (cyc >= next_ok) && !flush_i &&
                     ((head != 8'h52) || tx_ready_i);
        cur_strobe = exp_valid;
        @(posedge clk_i);
        #1;
        exp_valid = issue;
        if (issue) begin
            exp_data = head;
            void'(mq.pop_front());
            next_ok = cyc + 1 + longint'(div_i);
        end
        if (flush_i) begin
            mq.delete();
            next_ok    = cyc + 1;
            exp_issued = 16'd0;
            exp_stall  = 16'd0;
        end else begin
            if (push_ok) mq.push_back(usb_data_i);
            if (cur_strobe) exp_issued = exp_issued + 16'd1;
            if (nonempty && !issue) exp_stall = exp_stall + 16'd1;
        end
        exp_level = 5'(mq.size());
        exp_ready = (mq.size() < DEPTH);
        cyc++;
    endtask

    task automatic test_reset();
        rst_n_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        total++;
        if ({cmd_valid_o, cmd_data_o, level_o, usb_ready_o} !== {1'b0, 8'h00, 5'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_outputs got v=%b d=%h l=%0d r=%b want v=0 d=00 l=0 r=1",
                     cmd_valid_o, cmd_data_o, level_o, usb_ready_o);
        end
        rst_n_i = 1'b1;
        model_reset();
        $display("reset released at cycle %0d", cyc);
    endtask

    task automatic test_latency();
        logic [7:0] bytes [3];
        bytes[0] = 8'h30; bytes[1] = 8'h35; bytes[2] = 8'h37;
        div_i = '0;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 7; i++) begin
            usb_valid_i = (i < 3);
            usb_data_i  = (i < 3) ? bytes[i] : 8'h00;
            tick();
            total++;
            if ({cmd_valid_o, cmd_data_o, level_o, usb_ready_o} !== {exp_valid, exp_data, exp_level, exp_ready}) begin
                bad++;
                $display("FAIL latency_model cyc=%0d got v=%b d=%h l=%0d r=%b want v=%b d=%h l=%0d r=%b",
                         cyc, cmd_valid_o, cmd_data_o, level_o, usb_ready_o, exp_valid, exp_data, exp_level, exp_ready);
            end
            // Byte pushed in cycle 0 must appear in cycle 2, then 3 and 4.
            total++;
            if (cmd_valid_o !== (i >= 1 && i <= 3) ||
                ((i >= 1 && i <= 3) && cmd_data_o !== bytes[i-1])) begin
                bad++;
                $display("FAIL latency_strobe step=%0d got v=%b d=%h", i + 1, cmd_valid_o, cmd_data_o);
            end
            $display("latency step=%0d v=%b d=%h level=%0d", i + 1, cmd_valid_o, cmd_data_o, level_o);
        end
        usb_valid_i = 1'b0;
    endtask

    task automatic test_spacing();
        longint stamps[$];
        div_i = 8'd3;
        for (int i = 0; i < 24; i++) begin
            usb_valid_i = (i < 4);
            usb_data_i  = 8'hA1 + 8'(i);
            tick();
            total++;
            if ({cmd_valid_o, cmd_data_o, level_o, usb_ready_o} !== {exp_valid, exp_data, exp_level, exp_ready}) begin
                bad++;
                $display("FAIL spacing_model cyc=%0d got v=%b d=%h l=%0d r=%b want v=%b d=%h l=%0d r=%b",
                         cyc, cmd_valid_o, cmd_data_o, level_o, usb_ready_o, exp_valid, exp_data, exp_level, exp_ready);
            end
            if (cmd_valid_o === 1'b1) stamps.push_back(cyc);
        end
        usb_valid_i = 1'b0;
        total++;
        if (stamps.size() != 4) begin
            bad++;
            $display("FAIL spacing_count got %0d strobes want 4", stamps.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                total++;
                if (stamps[i] - stamps[i-1] != 4) begin
                    bad++;
                    $display("FAIL spacing_gap idx=%0d got %0d want 4", i, stamps[i] - stamps[i-1]);
                end
            end
        end
        $display("spacing strobes=%0d", stamps.size());
    endtask

    task automatic test_r_block();
        longint stamps[$];
        logic [7:0] got[$];
        div_i = 8'd3;
        tx_ready_i = 1'b0;
        for (int i = 0; i < 20; i++) begin
            usb_valid_i = (i < 2);
            usb_data_i  = (i == 0) ? 8'h52 : 8'h31;
            tx_ready_i  = (i >= 7);
            tick();
            total++;
            if ({cmd_valid_o, cmd_data_o, level_o, usb_ready_o} !== {exp_valid, exp_data, exp_level, exp_ready}) begin
                bad++;
                $display("FAIL rblock_model cyc=%0d got v=%b d=%h l=%0d r=%b want v=%b d=%h l=%0d r=%b",
                         cyc, cmd_valid_o, cmd_data_o, level_o, usb_ready_o, exp_valid, exp_data, exp_level, exp_ready);
            end
            if (i == 6) begin
                total++;
                if (level_o !== 5'd2 || stamps.size() != 0) begin
                    bad++;
                    $display("FAIL rblock_hold got level=%0d strobes=%0d want level=2 strobes=0", level_o, stamps.size());
                end
            end
            if (cmd_valid_o === 1'b1) begin
                stamps.push_back(cyc);
                got.push_back(cmd_data_o);
            end
        end
        usb_valid_i = 1'b0;
        total++;
        if (got.size() != 2 || got[0] !== 8'h52 || got[1] !== 8'h31 || stamps[1] - stamps[0] != 4) begin
            bad++;
            $display("FAIL rblock_release got %0d strobes, want R then 1 four cycles apart", got.size());
        end
        $display("rblock strobes=%0d", got.size());
    endtask

    task automatic test_full();
        logic [7:0] sent[$];
        logic [7:0] got[$];
        logic [7:0] nxt;
        bit         saw_full;
        saw_full = 0;
        nxt = 8'h80;
        div_i = 8'd255;
        tx_ready_i = 1'b1;
        for (int i = 0; i < 330; i++) begin
            usb_valid_i = (i < 24);
            usb_data_i  = nxt;
            if (i == 24) div_i = '0;
            if (usb_valid_i && usb_ready_o) begin
                sent.push_back(nxt);
                nxt = nxt + 8'd1;
            end
            tick();
            total++;
            if ({cmd_valid_o, cmd_data_o, level_o, usb_ready_o} !== {exp_valid, exp_data, exp_level, exp_ready}) begin
                bad++;
                $display("FAIL full_model cyc=%0d got v=%b d=%h l=%0d r=%b want v=%b d=%h l=%0d r=%b",
                         cyc, cmd_valid_o, cmd_data_o, level_o, usb_ready_o, exp_valid, exp_data, exp_level, exp_ready);
            end
            if (level_o === 5'd16) begin
                saw_full = 1;
                total++;
                if (usb_ready_o !== 1'b0) begin
                    bad++;
                    $display("FAIL full_ready got ready=%b at level 16 want 0", usb_ready_o);
                end
            end
            if (cmd_valid_o === 1'b1) got.push_back(cmd_data_o);
        end
        usb_valid_i = 1'b0;
        total++;
        if (!saw_full || got.size() != sent.size() || sent.size() != 17) begin
            bad++;
            $display("FAIL full_count got strobes=%0d sent=%0d saw_full=%0d want 17 17 1",
                     got.size(), sent.size(), saw_full);
        end else begin
            for (int i = 0; i < sent.size(); i++) begin
                total++;
                if (got[i] !== sent[i]) begin
                    bad++;
                    $display("FAIL full_order idx=%0d got %h want %h", i, got[i], sent[i]);
                end
            end
        end
        $display("full sent=%0d strobed=%0d", sent.size(), got.size());
    endtask

    task automatic test_flush();
        int strobes;
        strobes = 0;
        div_i = '0;
        tx_ready_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            usb_valid_i = (i < 5);
            usb_data_i  = (i == 0) ? 8'h52 : 8'h40 + 8'(i);
            tick();
        end
        total++;
        if (level_o !== 5'd5) begin
            bad++;
            $display("FAIL flush_prefill got level=%0d want 5", level_o);
        end
        flush_i = 1'b1;
        usb_valid_i = 1'b1;
        usb_data_i = 8'hEE;
        tick();
        flush_i = 1'b0;
        usb_valid_i = 1'b0;
        total++;
        if (level_o !== 5'd0 || usb_ready_o !== 1'b1) begin
            bad++;
            $display("FAIL flush_level got level=%0d ready=%b want 0 1", level_o, usb_ready_o);
        end
        tx_ready_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++;
            if ({cmd_valid_o, cmd_data_o, level_o, usb_ready_o} !== {exp_valid, exp_data, exp_level, exp_ready}) begin
                bad++;
                $display("FAIL flush_model cyc=%0d got v=%b d=%h l=%0d r=%b want v=%b d=%h l=%0d r=%b",
                         cyc, cmd_valid_o, cmd_data_o, level_o, usb_ready_o, exp_valid, exp_data, exp_level, exp_ready);
            end
            if (cmd_valid_o === 1'b1) strobes++;
        end
        total++;
        if (strobes != 0) begin
            bad++;
            $display("FAIL flush_nostrobe got %0d strobes want 0", strobes);
        end
        $display("flush strobes_after=%0d", strobes);
    endtask

    task automatic test_random(input int n);
        for (int i = 0; i < n; i++) begin
            usb_valid_i = ($urandom_range(0, 9) < 6);
            usb_data_i  = ($urandom_range(0, 3) == 0) ? 8'h52 : 8'($urandom);
            tx_ready_i  = ($urandom_range(0, 9) < 7);
            flush_i     = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 15) == 0) div_i = DIV_W'($urandom_range(0, 4));
            tick();
            total++;
            if ({cmd_valid_o, cmd_data_o, level_o, usb_ready_o} !== {exp_valid, exp_data, exp_level, exp_ready}) begin
                bad++;
                $display("FAIL random_model cyc=%0d got v=%b d=%h l=%0d r=%b want v=%b d=%h l=%0d r=%b",
                         cyc, cmd_valid_o, cmd_data_o, level_o, usb_ready_o, exp_valid, exp_data, exp_level, exp_ready);
            end
`ifdef JTAG_CMD_PACER_STATS_EN
            total++;
            if ({issued_cnt_o, stall_cnt_o} !== {exp_issued, exp_stall}) begin
                bad++;
                $display("FAIL random_stats cyc=%0d got issued=%0d stall=%0d want %0d %0d",
                         cyc, issued_cnt_o, stall_cnt_o, exp_issued, exp_stall);
            end
`endif
        end
        usb_valid_i = 1'b0;
        flush_i = 1'b0;
        tx_ready_i = 1'b1;
        $display("random cycles=%0d level=%0d", n, level_o);
    endtask

    task automatic test_reset_mid();
        div_i = 8'd200;
        for (int i = 0; i < 4; i++) begin
            usb_valid_i = 1'b1;
            usb_data_i  = 8'h60 + 8'(i);
            tick();
        end
        usb_valid_i = 1'b0;
        #2;
        rst_n_i = 1'b0;
        #1;
        total++;
        if ({cmd_valid_o, cmd_data_o, level_o, usb_ready_o} !== {1'b0, 8'h00, 5'd0, 1'b1}) begin
            bad++;
            $display("FAIL reset_mid got v=%b d=%h l=%0d r=%b want v=0 d=00 l=0 r=1",
                     cmd_valid_o, cmd_data_o, level_o, usb_ready_o);
        end
        @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        model_reset();
        div_i = '0;
        $display("mid-operation reset done at cycle %0d", cyc);
    endtask

`ifdef JTAG_CMD_PACER_STATS_EN
    task automatic test_stats();
        div_i = '0;
        tx_ready_i = 1'b1;
        repeat (3) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        for (int i = 0; i < 22; i++) begin
            usb_valid_i = (i < 10);
            usb_data_i  = (i == 0) ? 8'h52 : 8'h30 + 8'(i);
            tx_ready_i  = (i >= 7);
            tick();
            total++;
            if ({cmd_valid_o, cmd_data_o, level_o, issued_cnt_o, stall_cnt_o} !==
                {exp_valid, exp_data, exp_level, exp_issued, exp_stall}) begin
                bad++;
                $display("FAIL stats_model cyc=%0d got v=%b d=%h l=%0d i=%0d s=%0d want v=%b d=%h l=%0d i=%0d s=%0d",
                         cyc, cmd_valid_o, cmd_data_o, level_o, issued_cnt_o, stall_cnt_o,
                         exp_valid, exp_data, exp_level, exp_issued, exp_stall);
            end
        end
        usb_valid_i = 1'b0;
        total++;
        if (issued_cnt_o !== 16'd10 || stall_cnt_o !== 16'd6) begin
            bad++;
            $display("FAIL stats_counts got issued=%0d stall=%0d want 10 6", issued_cnt_o, stall_cnt_o);
        end
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total++;
        if (issued_cnt_o !== 16'd0 || stall_cnt_o !== 16'd0) begin
            bad++;
            $display("FAIL stats_flush got issued=%0d stall=%0d want 0 0", issued_cnt_o, stall_cnt_o);
        end
        $display("stats issued/stall checked and cleared");
    endtask
`endif

    initial begin
        test_reset();
        test_latency();
        test_spacing();
        test_r_block();
        test_full();
        test_flush();
        test_random(3000);
        test_reset_mid();
        test_random(500);
`ifdef JTAG_CMD_PACER_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
